// File: rtl/xif_copro_alu.sv
// xif_copro_alu: CV-X-IF coprocessor endpoint for the custom-0 ALU ops
// CADD, CPOP and CMAX. It handles one offloaded instruction at a time.
// Build option: define XIF_COPRO_MUL_EN to accept CMUL (funct3=011) and
// build the 32-cycle shift-add multiplier. Without it, CMUL is rejected.
module xif_copro_alu #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE     = 7'b0001011
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [31:0]           issue_instr,
    input  logic [X_ID_WIDTH-1:0] issue_id,
    output logic                  issue_accept,
    output logic                  issue_writeback,
    output logic [1:0]            issue_register_read,
    output logic                  issue_loadstore,
    input  logic                  register_valid,
    output logic                  register_ready,
    input  logic [X_ID_WIDTH-1:0] register_id,
    input  logic [31:0]           register_rs0,
    input  logic [31:0]           register_rs1,
    input  logic [1:0]            register_rs_valid,
    input  logic                  commit_valid,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic                  commit_kill,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [X_ID_WIDTH-1:0] result_id,
    output logic [31:0]           result_data,
    output logic [4:0]            result_rd,
    output logic                  result_we,
    output logic                  result_exc,
    output logic                  result_dbg,
    output logic                  result_err,
    output logic [5:0]            result_exccode
);

    typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_e;

    localparam logic [2:0] F3Add = 3'b000;
    localparam logic [2:0] F3Pop = 3'b001;
    localparam logic [2:0] F3Max = 3'b010;
    localparam logic [2:0] F3Mul = 3'b011;

    state_e                state_q, state_d;
    logic [X_ID_WIDTH-1:0] id_q;
    logic [4:0]            rd_q;
    logic [2:0]            funct3_q;
    logic                  have_ops_q, committed_q;
    logic [31:0]           op_a_q, op_b_q;
    logic                  result_valid_q, result_we_q;
    logic [X_ID_WIDTH-1:0] result_id_q;
    logic [31:0]           result_data_q;
    logic [4:0]            result_rd_q;

    logic        op_known;
    logic [1:0]  req_ops;
    logic        reg_match, ops_short, reg_take, commit_match, issue_take;
    logic [31:0] alu_res, exec_res;
    logic        exec_done;
    logic        unused_instr;

    // rs1/rs2 index fields are irrelevant: operands arrive on the register interface
    assign unused_instr = ^issue_instr[24:15];

    // Combinational decode of the offered instruction
    always_comb begin
        op_known = 1'b0;
        case (issue_instr[14:12])
            F3Add, F3Pop, F3Max: op_known = 1'b1;
`ifdef XIF_COPRO_MUL_EN
            F3Mul: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    assign issue_accept = op_known && (issue_instr[6:0] == OPCODE) &&
                          (issue_instr[31:25] == 7'd0);
    assign issue_register_read = !issue_accept ? 2'b00 :
                                 (issue_instr[14:12] == F3Pop) ? 2'b01 : 2'b11;
    assign issue_writeback = issue_accept && (issue_instr[11:7] != 5'd0);
    assign issue_loadstore = 1'b0;
    assign issue_ready     = !rst && (state_q == StIdle);
    assign issue_take      = issue_valid && issue_ready && issue_accept;

    // Operand and commit matching against the tracked instruction
    assign req_ops        = (funct3_q == F3Pop) ? 2'b01 : 2'b11;
    assign reg_match      = register_valid && (state_q == StWait) && (register_id == id_q);
    assign ops_short      = (register_rs_valid & req_ops) != req_ops;
    assign register_ready = !rst && !(reg_match && ops_short);
    assign reg_take       = reg_match && register_ready;
    assign commit_match   = commit_valid && (state_q == StWait) && (commit_id == id_q);

    // Single-cycle ALU on the captured operands
    always_comb begin
        alu_res = '0;
        case (funct3_q)
            F3Add: alu_res = op_a_q + op_b_q;
            F3Pop: begin
                for (int i = 0; i < 32; i++) begin
                    alu_res = alu_res + 32'(op_a_q[i]);
                end
            end
            F3Max: alu_res = ($signed(op_a_q) > $signed(op_b_q)) ? op_a_q : op_b_q;
            default: alu_res = '0;
        endcase
    end

`ifdef XIF_COPRO_MUL_EN
    logic [31:0] acc_q, acc_next;
    logic [4:0]  cnt_q;
    logic        is_mul;

    // op_a_q shifts left and op_b_q right, so bit 0 of op_b_q is the current multiplier bit
    assign is_mul    = (funct3_q == F3Mul);
    assign acc_next  = acc_q + (op_b_q[0] ? op_a_q : 32'd0);
    assign exec_done = !is_mul || (cnt_q == 5'd31);
    assign exec_res  = is_mul ? acc_next : alu_res;
`else
    assign exec_done = 1'b1;
    assign exec_res  = alu_res;
`endif

    // Next-state; the cycle completing both handshakes goes straight to EXEC
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (issue_take) state_d = StWait;
            StWait: begin
                if (commit_match && commit_kill) begin
                    state_d = StIdle;
                end else if ((have_ops_q || reg_take) && (committed_q || commit_match)) begin
                    state_d = StExec;
                end
            end
            StExec: if (exec_done) state_d = StResp;
            StResp: if (result_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, tracked instruction, operands and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            id_q           <= '0;
            rd_q           <= '0;
            funct3_q       <= '0;
            have_ops_q     <= 1'b0;
            committed_q    <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_data_q  <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
`ifdef XIF_COPRO_MUL_EN
            acc_q          <= '0;
            cnt_q          <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (issue_take) begin
                id_q        <= issue_id;
                rd_q        <= issue_instr[11:7];
                funct3_q    <= issue_instr[14:12];
                have_ops_q  <= 1'b0;
                committed_q <= 1'b0;
`ifdef XIF_COPRO_MUL_EN
                acc_q       <= '0;
                cnt_q       <= '0;
`endif
            end
            if (reg_take) begin
                op_a_q     <= register_rs0;
                op_b_q     <= register_rs1;
                have_ops_q <= 1'b1;
            end
            if (commit_match && !commit_kill) begin
                committed_q <= 1'b1;
            end
`ifdef XIF_COPRO_MUL_EN
            if (state_q == StExec && is_mul) begin
                acc_q  <= acc_next;
                cnt_q  <= cnt_q + 5'd1;
                op_a_q <= op_a_q << 1;
                op_b_q <= op_b_q >> 1;
            end
`endif
            if (state_q == StExec && exec_done) begin
                result_valid_q <= 1'b1;
                result_id_q    <= id_q;
                result_data_q  <= exec_res;
                result_rd_q    <= rd_q;
                result_we_q    <= (rd_q != 5'd0);
            end
            if (state_q == StResp && result_ready) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign result_valid   = result_valid_q;
    assign result_id      = result_id_q;
    assign result_data    = result_data_q;
    assign result_rd      = result_rd_q;
    assign result_we      = result_we_q;
    assign result_exc     = 1'b0;
    assign result_dbg     = 1'b0;
    assign result_err     = 1'b0;
    assign result_exccode = 6'd0;

endmodule
